// File: rtl/mem_req_router.sv
// mem_req_router: steers one core load/store at a time to one of NSLV
// memory-mapped targets by address region (addr[31:28]), waits for that
// target's ack and returns a single-cycle response. Unmapped regions and
// zero-byte-enable stores answer immediately with an error; a target that
// never acks is cut off after TIMEOUT busy cycles.
module mem_req_router #(
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_be,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [NSLV-1:0]      s_valid,
    output logic                 s_we,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_be,
    input  logic [NSLV-1:0]      s_ack,
    input  logic [NSLV*32-1:0]   s_rdata
);

    localparam logic [4:0] NSLV_L   = 5'(NSLV);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        ack_sel;
    logic [31:0] rdata_sel;
    logic        dec_err;

    // Pick the selected target's ack and read data; other targets are ignored
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == 4'(i)) begin
                ack_sel   = s_ack[i];
                rdata_sel = s_rdata[i*32 +: 32];
            end
        end
    end

    // Unmapped region, or a store that would write no bytes
    assign dec_err = ({1'b0, req_addr[31:28]} >= NSLV_L) || (req_we && (req_be == 4'b0000));

    // Next-state and datapath capture for the IDLE/BUSY/RESP handshake
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    sel_d   = req_addr[31:28];
                    if (dec_err) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                // An ack on the final allowed cycle still wins over the timeout
                if (ack_sel) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : rdata_sel;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured request registers; reset drops any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // One-hot strobe decoded from state only, so s_ack never reaches an output
    for (genvar g = 0; g < NSLV; g++) begin : g_strobe
        assign s_valid[g] = (state_q == BUSY) && (sel_q == 4'(g));
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign s_we      = we_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_be      = be_q;

endmodule

// File: tb/tb_mem_req_router.sv
// Bench for mem_req_router: a table of directed transactions with hand-worked
// expectations, a few multi-cycle sequences (back-to-back, reset mid-BUSY),
// then random transactions scored against a transaction-level model.
module tb_mem_req_router;

    localparam int NSLV    = 4;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 255;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [31:0]         req_addr;
    logic [31:0]         req_wdata;
    logic [3:0]          req_be;
    logic                rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic [NSLV-1:0]     s_valid;
    logic                s_we;
    logic [31:0]         s_addr;
    logic [31:0]         s_wdata;
    logic [3:0]          s_be;
    logic [NSLV-1:0]     s_ack;
    logic [NSLV*32-1:0]  s_rdata;

    mem_req_router #(.NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_be(s_be), .s_ack(s_ack), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    // dly: cycles after s_valid rises until the target acks (>= TIMEOUT: never in time)
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          dly;
        logic [31:0] adata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_svc;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Transaction-level reference: outcome follows from region, be and ack delay
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   sel;
        r   = v;
        sel = int'(v.addr[31:28]);
        if (sel >= NSLV || (v.we && v.be == 4'b0000)) begin
            r.exp_err = 1'b1; r.exp_rdata = 32'h0; r.exp_lat = 1; r.exp_svc = 0;
        end else if (v.dly < TIMEOUT) begin
            r.exp_err   = 1'b0;
            r.exp_rdata = v.we ? 32'h0 : v.adata;
            r.exp_lat   = v.dly + 2;
            r.exp_svc   = v.dly + 1;
        end else begin
            r.exp_err = 1'b1; r.exp_rdata = 32'h0; r.exp_lat = TIMEOUT + 1; r.exp_svc = TIMEOUT;
        end
        return r;
    endfunction

    // Drive one request (called at posedge+1), play the targets, check the outcome
    task automatic run_txn(input vec_t v, input string tag);
        int              sel;
        logic [NSLV-1:0] mask;
        int              svc;
        int              lat;
        logic            got;
        logic            bad;
        logic [31:0]     rd;
        logic            er;
        sel  = int'(v.addr[31:28]);
        mask = '0;
        if (sel < NSLV) mask[sel] = 1'b1;
        svc = 0; lat = 0; got = 1'b0; bad = 1'b0; rd = '0; er = 1'b0;
        chk({tag, ".ready_in"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~v.we; req_addr = $urandom; req_wdata = $urandom; req_be = ~v.be;
        for (int c = 1; c <= TIMEOUT + 8 && !got; c++) begin
            s_ack = NSLV'($urandom) & ~mask;
            if (c == v.dly + 1) s_ack = s_ack | mask;
            for (int i = 0; i < NSLV; i++)
                s_rdata[i*32 +: 32] = (i == sel) ? ((c == v.dly + 1) ? v.adata : $urandom)
                                                 : 32'hFFFF_FFFF;
            if (s_valid != '0) begin
                svc++;
                if (s_valid !== mask) bad = 1'b1;
            end
            if (rsp_valid === 1'b1) begin
                got = 1'b1; lat = c; rd = rsp_rdata; er = rsp_err;
            end
            @(posedge clk); #1;
        end
        s_ack = '0;
        chk({tag, ".rsp_seen"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, ".svalid_cycles"}, 32'(svc), 32'(v.exp_svc));
        chk({tag, ".svalid_onehot"}, 32'(bad), 32'd0);
        chk({tag, ".rsp_err"}, 32'(er), 32'(v.exp_err));
        chk({tag, ".rsp_rdata"}, rd, v.exp_rdata);
        chk({tag, ".rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
        chk({tag, ".s_addr"}, s_addr, v.addr);
        chk({tag, ".s_wdata"}, s_wdata, v.wdata);
        chk({tag, ".s_be"}, 32'(s_be), 32'(v.be));
        chk({tag, ".s_we"}, 32'(s_we), 32'(v.we));
    endtask

    vec_t tbl[9];

    initial begin
        vec_t        v;
        int          n;
        logic [3:0]  rsp_pat;
        logic [3:0]  rdy_pat;
        logic [3:0]  top;
        int          r;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; s_ack = '0; s_rdata = '0;

        // Reset state
        #2;
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_rdata", rsp_rdata, 32'd0);
        chk("reset.rsp_err", 32'(rsp_err), 32'd0);
        chk("reset.s_valid", 32'(s_valid), 32'd0);
        chk("reset.s_addr", s_addr, 32'd0);
        chk("reset.s_wdata", s_wdata, 32'd0);
        chk("reset.s_be_we", {27'd0, s_we, s_be}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: addr, we, wdata, be, dly, adata, err, rdata, lat, svc
        tbl[0] = '{32'h0000_0010, 1'b0, 32'h0,         4'hF, 1,     32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3,  2};
        tbl[1] = '{32'h2000_0004, 1'b1, 32'h1234_5678, 4'h3, 0,     32'hAAAA_5555, 1'b0, 32'h0,         2,  1};
        tbl[2] = '{32'h7000_0000, 1'b0, 32'h0,         4'hF, 0,     32'h1111_1111, 1'b1, 32'h0,         1,  0};
        tbl[3] = '{32'h3000_0000, 1'b1, 32'hCAFE_F00D, 4'h0, 0,     32'h2222_2222, 1'b1, 32'h0,         1,  0};
        tbl[4] = '{32'h1000_0000, 1'b0, 32'h0,         4'hF, NEVER, 32'h3333_3333, 1'b1, 32'h0,         16, 15};
        tbl[5] = '{32'h1000_0008, 1'b0, 32'h0,         4'hF, 14,    32'h0000_5A5A, 1'b0, 32'h0000_5A5A, 16, 15};
        tbl[6] = '{32'h0000_0100, 1'b0, 32'h0,         4'hF, 3,     32'h0000_0001, 1'b0, 32'h0000_0001, 5,  4};
        tbl[7] = '{32'h3FFF_FFFC, 1'b1, 32'h0BAD_CAFE, 4'hC, 2,     32'h4444_4444, 1'b0, 32'h0,         4,  3};
        tbl[8] = '{32'hF000_0000, 1'b1, 32'h5555_AAAA, 4'hF, 0,     32'h6666_6666, 1'b1, 32'h0,         1,  0};
        for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back: req_valid held high on an unmapped address
        rsp_pat = '0; rdy_pat = '0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h9000_0000; req_be = 4'hF;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 4) req_valid = 1'b0;
            rsp_pat[c-1] = rsp_valid;
            rdy_pat[c-1] = req_ready;
        end
        chk("b2b.rsp_pattern", 32'(rsp_pat), 32'h5);
        chk("b2b.ready_pattern", 32'(rdy_pat), 32'hA);
        @(posedge clk); #1;

        // Reset asserted while target 2 is being strobed
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2000_0040; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy.pre_s_valid", 32'(s_valid), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy.s_valid", 32'(s_valid), 32'd0);
        chk("rst_busy.req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy.s_addr", s_addr, 32'd0);
        chk("rst_busy.s_be_we", {27'd0, s_we, s_be}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1 || s_valid !== '0) n++;
        end
        chk("rst_busy.no_rsp_after", 32'(n), 32'd0);
        v = '{32'h2000_0080, 1'b1, 32'h8765_4321, 4'hF, 1, 32'h0, 1'b0, 32'h0, 3, 2};
        run_txn(v, "rst_busy.next");

        // Random transactions against the model
        for (int k = 0; k < 40; k++) begin
            top = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            v.addr  = {top, 28'($urandom)};
            v.we    = 1'($urandom);
            v.wdata = $urandom;
            v.be    = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            r       = int'($urandom_range(0, 9));
            v.dly   = (r < 6) ? int'($urandom_range(0, 4)) :
                      (r == 6) ? TIMEOUT - 1 : (r == 7) ? TIMEOUT : NEVER;
            v.adata = $urandom;
            v       = model(v);
            run_txn(v, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_req_router.md
# mem_req_router

Sequential request router on the data side of the RV32I core. It accepts one load/store request at a time from the load/store path and steers it to exactly one of `NSLV` memory-mapped targets (data memory, UART, timer, GPIO) based on the address region. It waits for that target's acknowledge and returns a single-cycle response pulse to the core. It is the write/steer counterpart of the result-select mux on the return path, and adds decode-error and timeout handling.

## Interface
- `NSLV`, 4: number of targets; valid range 1..15.
- `TIMEOUT`, 15: maximum BUSY cycles allowed without an acknowledge; valid range 1..255.

- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: the core presents a request.
- `req_ready` output 1: the router can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data.
- `req_be` input 4: byte enables.
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output 32: load data; 0 on error or store.
- `rsp_err` output 1: decode error, timeout, or store with `req_be == 0`. Qualified by `rsp_valid`.
- `s_valid` output NSLV: one-hot request strobe to the targets.
- `s_we` output 1: shared registered copy of `req_we`.
- `s_addr` output 32: shared registered copy of `req_addr`.
- `s_wdata` output 32: shared registered copy of `req_wdata`.
- `s_be` output 4: shared registered copy of `req_be`.
- `s_ack` input NSLV: per-target acknowledge.
- `s_rdata` input NSLV*32: per-target read data; target i occupies bits [32i+31:32i].

## Operation
- Region decode uses `sel = req_addr[31:28]`.
  - `sel < NSLV`: the request routes to target `sel`.
  - Otherwise: decode error.
- FSM states: IDLE, BUSY, RESP.
  - **IDLE:** `req_ready = 1`. When `req_valid` is high, capture `we/addr/wdata/be/sel` into registers.
    - Decode error, or `req_we && req_be == 0`: go to RESP with error.
    - Otherwise: go to BUSY and clear the timeout counter.
  - **BUSY:** `s_valid[sel] = 1`; all other `s_valid` bits are 0.
    - If `s_ack[sel] = 1`: latch `s_rdata[sel]` (load) or 0 (store) and go to RESP with `err = 0`.
    - Else, if the counter equals `TIMEOUT - 1`: go to RESP with `err = 1` and rdata 0.
    - Else: increment the counter.
  - **RESP:** `rsp_valid = 1` for exactly one cycle, with registered `rsp_rdata`/`rsp_err`. Then go to IDLE.
- `s_ack` bits from non-selected targets are ignored in every state. `s_ack` in IDLE or RESP is ignored.
- `s_we/s_addr/s_wdata/s_be` stay stable from the accept edge until the next accepted request.
- Counter width: 8 bits, saturating; it never wraps.
- Reset (asserted at any time, including mid-BUSY):
  - Go to IDLE immediately and asynchronously.
  - `req_ready = 1`.
  - `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_err = 0`.
  - `s_valid = 0`.
  - `s_we = 0`, `s_addr = 0`, `s_wdata = 0`, `s_be = 0`.
  - Counter = 0.
  - An in-flight request is dropped with no response.

## Timing
- Accept at edge T, with `req_valid && req_ready` sampled high.
- Normal request, acknowledged k cycles after `s_valid` rises (k ≥ 0):
  - `s_valid` is high during cycle T+1 through T+1+k.
  - `rsp_valid` is high during cycle T+2+k.
  - `req_ready` returns during cycle T+3+k.
- Minimum latency: k = 0 gives 2 cycles from accept to response.
- Error at decode: `rsp_valid` is high in cycle T+1 with `rsp_err = 1`; `s_valid` is never asserted.
- Timeout: `s_valid` is high for exactly `TIMEOUT` cycles, then `rsp_valid` and `rsp_err` are high in the next cycle.
- Ack coinciding with the last timeout cycle: the ack takes priority, giving `err = 0`.
- Back-to-back requests: the next accept occurs no earlier than the cycle after RESP. `req_valid` held high is taken at the first IDLE edge.
- No combinational path from `s_ack` or `s_rdata` to any output. All outputs are registered or decoded from state only.

## Test plan
- **Load from target 0:** addr 0x0000_0010, target 0 acks with 0xDEAD_BEEF one cycle after `s_valid` -> `s_valid = 4'b0001` for 2 cycles, then `rsp_valid` with `rsp_rdata = 0xDEAD_BEEF`, `rsp_err = 0`, 3 cycles after accept.
- **Store to target 2:** addr 0x2000_0004, wdata 0x1234_5678, be 4'b0011, immediate ack -> `s_valid = 4'b0100` for 1 cycle with `s_be = 4'b0011`, then `rsp_valid`, `rsp_rdata = 0`, `rsp_err = 0`.
- **Decode error:** addr 0x7000_0000 with `NSLV = 4` -> `s_valid` stays 0, `rsp_valid` and `rsp_err` high in the cycle after accept, `rsp_rdata = 0`. Repeat with a store using `be = 0` -> same result.
- **Timeout:** target 1 never acks, `TIMEOUT = 15` -> `s_valid[1]` high exactly 15 cycles, then `rsp_err = 1`. A variant acks on the 15th cycle -> `rsp_err = 0`.
- **Stray ack:** target 3 acks with 0xFFFF_FFFF while target 0 is selected -> ignored. A later target 0 ack with 0x0000_0001 returns 0x0000_0001.
- **Reset mid-BUSY:** `rst_n` pulled low asynchronously with `s_valid[2]` high -> `s_valid = 0` and `req_ready = 1` without waiting for a clock edge. No `rsp_valid` after release. The next request completes normally.
